// File: rtl/ch_msg_block_receiver_pkg.sv
// Decoder front-end shared definitions.
// Holds the default block geometry, the receiver read-FSM state encoding and
// a helper that sizes segment index ports.
package ch_msg_block_receiver_pkg;

  // Default block geometry: a block of 204 four-bit messages, streamed as four
  // segments of 51 messages each.
  localparam int CH_N         = 204;
  localparam int CH_QUAN_SIZE = 4;
  localparam int CH_SEG_SIZE  = 51;
  localparam int CH_SEG_NUM   = CH_N / CH_SEG_SIZE;

  // Read-side FSM. It is idle when no block is buffered, and streams
  // segments while a block is buffered.
  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Width of a segment index. The result is never zero, so a one-segment
  // configuration still has a legal 1-bit port.
  function automatic int seg_idx_width(input int seg_num);
    return (seg_num > 1) ? $clog2(seg_num) : 1;
  endfunction

endpackage

// File: rtl/ch_msg_block_receiver_seg_mux.sv
// Segment selector: picks one SEG_SIZE-message slice out of a buffered block.
// Segment 0 is the most-significant slice, which holds the earliest-generated
// messages.
module ch_msg_seg_mux
  import ch_msg_block_receiver_pkg::*;
#(
  parameter int N         = CH_N,
  parameter int QUAN_SIZE = CH_QUAN_SIZE,
  parameter int SEG_SIZE  = CH_SEG_SIZE
) (
  input  logic [N*QUAN_SIZE-1:0]                   block,
  input  logic [seg_idx_width(N / SEG_SIZE)-1:0]   seg_idx,
  output logic [SEG_SIZE*QUAN_SIZE-1:0]            seg_data
);

  localparam int SEG_NUM = N / SEG_SIZE;
  localparam int IDX_W   = seg_idx_width(SEG_NUM);
  localparam int SEG_W   = SEG_SIZE * QUAN_SIZE;

  // Choose the slice selected by seg_idx. An out-of-range index yields zeros.
  always_comb begin
    seg_data = '0;
    for (int k = 0; k < SEG_NUM; k++) begin
      if (seg_idx == IDX_W'(k)) begin
        seg_data = block[(N - k * SEG_SIZE) * QUAN_SIZE - 1 -: SEG_W];
      end
    end
  end

endmodule

// File: rtl/ch_msg_block_receiver.sv
// Channel-message block receiver.
// It captures whole coded blocks into a ping-pong buffer pair, then streams
// each block to the decoder one segment at a time using a valid/ready
// handshake. It also counts streamed blocks and dropped blocks.
module ch_msg_block_receiver
  import ch_msg_block_receiver_pkg::*;
#(
  parameter int N         = CH_N,
  parameter int QUAN_SIZE = CH_QUAN_SIZE,
  parameter int SEG_SIZE  = CH_SEG_SIZE
) (
  input  logic                                     sys_clk,
  input  logic                                     rstn,
  input  logic [N*QUAN_SIZE-1:0]                   coded_block,
  input  logic                                     tvalid_master,
  output logic                                     ready_slave,
  output logic [SEG_SIZE*QUAN_SIZE-1:0]            seg_data,
  output logic                                     seg_valid,
  input  logic                                     seg_ready,
  output logic [seg_idx_width(N / SEG_SIZE)-1:0]   seg_idx,
  output logic                                     seg_last,
  output logic [15:0]                              blk_cnt,
  output logic [15:0]                              drop_cnt,
  output logic                                     overflow_err
);

  localparam int BLK_W = N * QUAN_SIZE;
  localparam int SEG_NUM = N / SEG_SIZE;
  localparam int IDX_W = seg_idx_width(SEG_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEG_NUM - 1);

  logic [BLK_W-1:0] buf0;
  logic [BLK_W-1:0] buf1;
  logic [BLK_W-1:0] rd_block;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  rd_state_t        state;
  rd_state_t        state_next;
  logic [IDX_W-1:0] idx_next;
  logic             capture;
  logic             drop;
  logic             seg_fire;
  logic             release_blk;

  // ready_slave is decided from the occupancy before any release in the same
  // cycle. A block that arrives as the final segment is handed over is
  // accepted only when a buffer was already free.
  assign ready_slave = (occ < 2'd2);
  assign capture     = tvalid_master & ready_slave;
  assign drop        = tvalid_master & ~ready_slave;

  assign seg_valid   = (state == RD_STREAM);
  assign seg_last    = seg_valid & (seg_idx == LAST_IDX);
  assign seg_fire    = seg_valid & seg_ready;
  assign release_blk = seg_fire & (seg_idx == LAST_IDX);

  assign rd_block    = rd_ptr ? buf1 : buf0;

  // Load the incoming block into the buffer that the write pointer selects.
  // These buffers are not reset on purpose.
  always_ff @(posedge sys_clk) begin
    if (capture && !wr_ptr) begin
      buf0 <= coded_block;
    end
    if (capture && wr_ptr) begin
      buf1 <= coded_block;
    end
  end

  // Work out the occupancy after this cycle's capture and release.
  // A capture and a release in the same cycle cancel each other out.
  always_comb begin
    occ_next = occ;
    if (capture && !release_blk) begin
      occ_next = occ + 2'd1;
    end else if (!capture && release_blk) begin
      occ_next = occ - 2'd1;
    end
  end

  // Register the buffer pointers and the occupancy.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (capture) begin
        wr_ptr <= ~wr_ptr;
      end
      if (release_blk) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_next;
    end
  end

  // Read-FSM next state. After the final segment, the FSM moves straight to
  // the next buffered block, with no gap, whenever one remains.
  always_comb begin
    state_next = state;
    idx_next   = seg_idx;
    case (state)
      RD_IDLE: begin
        if (occ != 2'd0) begin
          state_next = RD_STREAM;
          idx_next   = '0;
        end
      end
      RD_STREAM: begin
        if (seg_fire) begin
          if (seg_idx == LAST_IDX) begin
            idx_next = '0;
            if (occ_next == 2'd0) begin
              state_next = RD_IDLE;
            end
          end else begin
            idx_next = seg_idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = RD_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Register the read-FSM state and the segment index.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RD_IDLE;
      seg_idx <= '0;
    end else begin
      state   <= state_next;
      seg_idx <= idx_next;
    end
  end

  // Update the status counters. The streamed-block count wraps around, the
  // drop count saturates, and the overflow flag stays set until reset.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt      <= 16'd0;
      drop_cnt     <= 16'd0;
      overflow_err <= 1'b0;
    end else begin
      if (release_blk) begin
        blk_cnt <= blk_cnt + 16'd1;
      end
      if (drop) begin
        overflow_err <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  ch_msg_seg_mux #(
    .N         (N),
    .QUAN_SIZE (QUAN_SIZE),
    .SEG_SIZE  (SEG_SIZE)
  ) u_seg_mux (
    .block    (rd_block),
    .seg_idx  (seg_idx),
    .seg_data (seg_data)
  );

endmodule

// File: tb/tb_ch_msg_block_receiver.sv
// Testbench for ch_msg_block_receiver.
// A table of per-cycle vectors drives the default-geometry receiver. A
// scoreboard queue holds the segment data expected for each accepted block.
// Hand-written sequences cover reset in mid-stream and the counter limits.
// A second, one-segment instance makes the 65536-block wrap quick to reach.
module tb_ch_msg_block_receiver;

  localparam int N       = 204;
  localparam int Q       = 4;
  localparam int SEG     = 51;
  localparam int SEG_NUM = N / SEG;
  localparam int BLK_W   = N * Q;
  localparam int SEG_W   = SEG * Q;

  logic              sys_clk = 1'b0;
  logic              rstn;
  logic [BLK_W-1:0]  coded_block;
  logic              tvalid_master;
  logic              ready_slave;
  logic [SEG_W-1:0]  seg_data;
  logic              seg_valid;
  logic              seg_ready;
  logic [1:0]        seg_idx;
  logic              seg_last;
  logic [15:0]       blk_cnt;
  logic [15:0]       drop_cnt;
  logic              overflow_err;

  // Signals for the small instance: N=2, one segment per block.
  logic [1:0]        s_block;
  logic              s_tvalid;
  logic              s_ready_slave;
  logic [1:0]        s_seg_data;
  logic              s_seg_valid;
  logic              s_seg_ready;
  logic [0:0]        s_seg_idx;
  logic              s_seg_last;
  logic [15:0]       s_blk_cnt;
  logic [15:0]       s_drop_cnt;
  logic              s_overflow_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [SEG_W-1:0] sb[$];

  typedef struct {
    logic tv;
    logic sr;
    int   seed;
    logic e_ready;
    logic e_valid;
    int   e_idx;
    logic e_last;
    int   e_blk;
    int   e_drop;
    logic e_ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 sys_clk = ~sys_clk;

  ch_msg_block_receiver dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .coded_block   (coded_block),
    .tvalid_master (tvalid_master),
    .ready_slave   (ready_slave),
    .seg_data      (seg_data),
    .seg_valid     (seg_valid),
    .seg_ready     (seg_ready),
    .seg_idx       (seg_idx),
    .seg_last      (seg_last),
    .blk_cnt       (blk_cnt),
    .drop_cnt      (drop_cnt),
    .overflow_err  (overflow_err)
  );

  ch_msg_block_receiver #(
    .N         (2),
    .QUAN_SIZE (1),
    .SEG_SIZE  (2)
  ) dut_small (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .coded_block   (s_block),
    .tvalid_master (s_tvalid),
    .ready_slave   (s_ready_slave),
    .seg_data      (s_seg_data),
    .seg_valid     (s_seg_valid),
    .seg_ready     (s_seg_ready),
    .seg_idx       (s_seg_idx),
    .seg_last      (s_seg_last),
    .blk_cnt       (s_blk_cnt),
    .drop_cnt      (s_drop_cnt),
    .overflow_err  (s_overflow_err)
  );

  // Message i of the block with the given seed. Seed 0 gives message i = i mod 16.
  function automatic logic [Q-1:0] msg_val(input int seed, input int i);
    return Q'((i + 5 * seed) & 15);
  endfunction

  function automatic logic [BLK_W-1:0] make_block(input int seed);
    logic [BLK_W-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      b[(N - 1 - i) * Q +: Q] = msg_val(seed, i);
    end
    return b;
  endfunction

  // Expected segment k, built message by message: the first message sits in the top bits.
  function automatic logic [SEG_W-1:0] exp_seg(input int seed, input int k);
    logic [SEG_W-1:0] s;
    s = '0;
    for (int j = 0; j < SEG; j++) begin
      s[(SEG - 1 - j) * Q +: Q] = msg_val(seed, k * SEG + j);
    end
    return s;
  endfunction

  function automatic vec_t mk(input logic tv, input logic sr, input int seed,
                              input logic e_ready, input logic e_valid, input int e_idx,
                              input logic e_last, input int e_blk, input int e_drop,
                              input logic e_ovf);
    vec_t v;
    v.tv = tv; v.sr = sr; v.seed = seed;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_idx = e_idx; v.e_last = e_last;
    v.e_blk = e_blk; v.e_drop = e_drop; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectOutputs(input string tag, input logic e_ready, input logic e_valid,
                               input int e_idx, input logic e_last, input int e_blk,
                               input int e_drop, input logic e_ovf);
    checkOutput({tag, "_ready_slave"}, 256'(ready_slave), 256'(e_ready));
    checkOutput({tag, "_seg_valid"}, 256'(seg_valid), 256'(e_valid));
    if (e_valid) begin
      checkOutput({tag, "_seg_idx"}, 256'(seg_idx), 256'(e_idx));
    end
    checkOutput({tag, "_seg_last"}, 256'(seg_last), 256'(e_last));
    checkOutput({tag, "_blk_cnt"}, 256'(blk_cnt), 256'(e_blk));
    checkOutput({tag, "_drop_cnt"}, 256'(drop_cnt), 256'(e_drop));
    checkOutput({tag, "_overflow_err"}, 256'(overflow_err), 256'(e_ovf));
  endtask

  // One cycle: drive the inputs on the falling edge, then check seg_data
  // against the scoreboard. The front entry is popped when the handshake
  // will complete. The segments of an accepted block are queued.
  task automatic applyStimulus(input logic tv, input logic sr, input int seed, input logic accept);
    @(negedge sys_clk);
    tvalid_master = tv;
    seg_ready     = sr;
    coded_block   = make_block(seed);
    #1;
    if (seg_valid) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL seg_data_unexpected: got valid segment idx %0d, expected no segment", seg_idx);
      end else begin
        checkOutput("seg_data", 256'(seg_data), 256'(sb[0]));
        if (sr) begin
          void'(sb.pop_front());
        end
      end
    end
    if (accept) begin
      for (int k = 0; k < SEG_NUM; k++) begin
        sb.push_back(exp_seg(seed, k));
      end
    end
  endtask

  initial begin
    rstn          = 1'b0;
    tvalid_master = 1'b0;
    seg_ready     = 1'b0;
    coded_block   = '0;
    s_block       = '0;
    s_tvalid      = 1'b0;
    s_seg_ready   = 1'b0;

    // Check the outputs while reset is held.
    repeat (3) @(negedge sys_clk);
    #1;
    expectOutputs("reset", 1, 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    rstn = 1'b1;

    // Fields: tv, sr, seed | ready, valid, idx, last, blk, drop, ovf
    // A single block with seg_ready held high.
    vecs.push_back(mk(1,1,1, 1,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,1,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,1,1,0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,1,2,0, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,1,3,1, 0,0,0));
    vecs.push_back(mk(0,1,0, 1,0,0,0, 1,0,0));
    // Three pulses while stalled: two are accepted and the third is dropped. Both blocks then stream with no gap.
    vecs.push_back(mk(1,0,2, 1,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,3, 1,0,0,0, 1,0,0));
    vecs.push_back(mk(1,0,0, 0,1,0,0, 1,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0, 1,1,1));
    vecs.push_back(mk(0,1,0, 0,1,0,0, 1,1,1));
    vecs.push_back(mk(0,1,0, 0,1,1,0, 1,1,1));
    vecs.push_back(mk(0,1,0, 0,1,2,0, 1,1,1));
    vecs.push_back(mk(0,1,0, 0,1,3,1, 1,1,1));
    vecs.push_back(mk(0,1,0, 1,1,0,0, 2,1,1));
    vecs.push_back(mk(0,1,0, 1,1,1,0, 2,1,1));
    vecs.push_back(mk(0,1,0, 1,1,2,0, 2,1,1));
    vecs.push_back(mk(0,1,0, 1,1,3,1, 2,1,1));
    vecs.push_back(mk(0,1,0, 1,0,0,0, 3,1,1));
    // A new block arrives on the same cycle as the final-segment handshake. It is accepted and streams with no gap.
    vecs.push_back(mk(1,1,4, 1,0,0,0, 3,1,1));
    vecs.push_back(mk(0,1,0, 1,0,0,0, 3,1,1));
    vecs.push_back(mk(0,1,0, 1,1,0,0, 3,1,1));
    vecs.push_back(mk(0,1,0, 1,1,1,0, 3,1,1));
    vecs.push_back(mk(0,1,0, 1,1,2,0, 3,1,1));
    vecs.push_back(mk(1,1,5, 1,1,3,1, 3,1,1));
    vecs.push_back(mk(0,1,0, 1,1,0,0, 4,1,1));
    vecs.push_back(mk(0,1,0, 1,1,1,0, 4,1,1));
    vecs.push_back(mk(0,1,0, 1,1,2,0, 4,1,1));
    vecs.push_back(mk(0,1,0, 1,1,3,1, 4,1,1));
    vecs.push_back(mk(0,0,0, 1,0,0,0, 5,1,1));
    // Block with message i = i mod 16. seg_ready toggles, and segments hold through the stalls.
    vecs.push_back(mk(1,0,0, 1,0,0,0, 5,1,1));
    vecs.push_back(mk(0,1,0, 1,0,0,0, 5,1,1));
    vecs.push_back(mk(0,1,0, 1,1,0,0, 5,1,1));
    vecs.push_back(mk(0,0,0, 1,1,1,0, 5,1,1));
    vecs.push_back(mk(0,1,0, 1,1,1,0, 5,1,1));
    vecs.push_back(mk(0,0,0, 1,1,2,0, 5,1,1));
    vecs.push_back(mk(0,1,0, 1,1,2,0, 5,1,1));
    vecs.push_back(mk(0,0,0, 1,1,3,1, 5,1,1));
    vecs.push_back(mk(0,1,0, 1,1,3,1, 5,1,1));
    vecs.push_back(mk(0,0,0, 1,0,0,0, 6,1,1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].tv, vecs[i].sr, vecs[i].seed, vecs[i].tv & vecs[i].e_ready);
      expectOutputs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_idx,
                    vecs[i].e_last, vecs[i].e_blk, vecs[i].e_drop, vecs[i].e_ovf);
    end

    // Reset while segment 2 of a block is on the output and a second block is buffered.
    applyStimulus(1, 1, 6, 1);
    expectOutputs("rst_pre0", 1, 0, 0, 0, 6, 1, 1);
    applyStimulus(1, 1, 7, 1);
    expectOutputs("rst_pre1", 1, 0, 0, 0, 6, 1, 1);
    applyStimulus(0, 1, 0, 0);
    expectOutputs("rst_pre2", 0, 1, 0, 0, 6, 1, 1);
    applyStimulus(0, 1, 0, 0);
    expectOutputs("rst_pre3", 0, 1, 1, 0, 6, 1, 1);
    applyStimulus(0, 0, 0, 0);
    expectOutputs("rst_pre4", 0, 1, 2, 0, 6, 1, 1);
    rstn = 1'b0;
    #1;
    expectOutputs("rst_async", 1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_async_seg_idx", 256'(seg_idx), 256'(0));
    sb.delete();
    @(negedge sys_clk);
    rstn = 1'b1;
    applyStimulus(1, 1, 8, 1);
    expectOutputs("rst_post0", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectOutputs("rst_post1", 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < SEG_NUM; k++) begin
      applyStimulus(0, 1, 0, 0);
      expectOutputs($sformatf("rst_seg%0d", k), 1, 1, k, (k == SEG_NUM - 1), 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 0);
    expectOutputs("rst_done", 1, 0, 0, 0, 1, 0, 0);

    // Counter limits. The main instance fills both buffers and then drops on
    // every cycle, giving drops on cycles 2 onward. The small instance hands
    // over one block per cycle from cycle 2 onward. Each check reads the
    // state left by cycles 0..c-1.
    for (int c = 0; c <= 65539; c++) begin
      @(negedge sys_clk);
      tvalid_master = 1'b1;
      seg_ready     = 1'b0;
      coded_block   = make_block(c & 7);
      s_tvalid      = 1'b1;
      s_seg_ready   = 1'b1;
      s_block       = 2'(c);
      #1;
      if (c == 65536) begin
        checkOutput("drop_cnt_65534", 256'(drop_cnt), 256'(65534));
      end
      if (c == 65537) begin
        checkOutput("drop_cnt_65535", 256'(drop_cnt), 256'(65535));
        checkOutput("small_blk_cnt_65535", 256'(s_blk_cnt), 256'(65535));
      end
      if (c == 65538) begin
        checkOutput("small_blk_cnt_wrap", 256'(s_blk_cnt), 256'(0));
        checkOutput("small_seg_valid", 256'(s_seg_valid), 256'(1));
        checkOutput("small_seg_last", 256'(s_seg_last), 256'(1));
        checkOutput("small_seg_idx", 256'(s_seg_idx), 256'(0));
        checkOutput("small_seg_data", 256'(s_seg_data), 256'(2'(c - 1)));
        checkOutput("small_ready_slave", 256'(s_ready_slave), 256'(1));
      end
      if (c == 65539) begin
        checkOutput("drop_cnt_saturated", 256'(drop_cnt), 256'(65535));
        checkOutput("overflow_err_long", 256'(overflow_err), 256'(1));
        checkOutput("small_blk_cnt_after_wrap", 256'(s_blk_cnt), 256'(1));
        checkOutput("small_drop_cnt", 256'(s_drop_cnt), 256'(1));
        checkOutput("small_overflow_err", 256'(s_overflow_err), 256'(1));
      end
    end
    tvalid_master = 1'b0;
    s_tvalid      = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
